store_write_buffer: RTL and testbench
=====================================

// Module: store_write_buffer
// PURPOSE
//  Posted-store FIFO between the MEM-stage store-lane aligner and the data-side memory port.
//  Accepts lane-aligned store data plus size/address, derives byte strobes, queues entries,
//  and drains them in order, one outstanding write at a time, over a req/addr_ok/data_ok port.
//  Lets the pipeline retire stores without waiting for memory write completion.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, 2..16
//  AW      32  address width
// PORTS
//  clk          in   1   single clock, rising edge
//  resetn       in   1   asynchronous active-low reset
//  st_valid     in   1   store request from MEM stage
//  st_size      in   2   00 byte, 01 half, 10 word; 11 illegal
//  st_addr      in   AW  byte address
//  st_wdata     in   32  data already placed on its byte lanes
//  st_ready     out  1   buffer can accept this cycle
//  st_err       out  1   misaligned/illegal request rejected (combinational)
//  sb_empty     out  1   no queued and no in-flight store
//  ld_valid     in   1   MEM-stage load probe
//  ld_addr      in   AW  load byte address
//  ld_conflict  out  1   load must stall (see CONFIGURATION)
//  mem_req      out  1   write request valid
//  mem_addr     out  AW  word-aligned address ({addr[AW-1:2],2'b00})
//  mem_size     out  2   copy of st_size
//  mem_wstrb    out  4   byte strobes
//  mem_wdata    out  32  write data
//  mem_addr_ok  in   1   request accepted
//  mem_data_ok  in   1   write completed
// BEHAVIOUR
//  - Reset: FIFO empty, pointers/count 0, FSM IDLE; mem_req=0, mem_addr/wstrb/wdata/size=0,
//    st_ready=1, sb_empty=1. Reset mid-transaction abandons it; no replay after reset.
//  - Strobes: byte -> 4'b0001<<addr[1:0]; half addr[1:0]=00 -> 0011, 10 -> 1100; word -> 1111.
//  - Legality: half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> st_err=st_valid,
//    entry not written. Legal: st_err=0.
//  - Enqueue when st_valid & st_ready & !st_err. st_ready = (count != DEPTH); no same-cycle
//    bypass of a pop into a full FIFO. Simultaneous push+pop: count unchanged.
//  - Drain FSM (one outstanding):
//    IDLE: count!=0 -> REQ, registering head entry onto mem_* next cycle.
//    REQ : mem_req=1, mem_* stable. addr_ok & data_ok same cycle -> pop; next REQ if more
//          entries remain else IDLE. addr_ok only -> WAIT.
//    WAIT: mem_req=0; data_ok -> pop; -> REQ if entries remain else IDLE.
//  - Min latency enqueue->mem_req: 2 cycles (enqueue edge, then IDLE->REQ edge).
//  - Head is popped only on data_ok; in-flight entry stays counted until then.
//  - sb_empty = (count==0) & (state==IDLE). data_ok outside WAIT/REQ ignored.
//  - Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
// CONFIGURATION
//  STBUF_RAW_CHK_EN defined: ld_conflict = ld_valid & any counted entry with matching
//    addr[AW-1:2] (includes in-flight head); same-cycle incoming store also compared.
//  Not defined: ld_conflict = ld_valid & (!sb_empty | (st_valid & !st_err)) (conservative).
// TESTING
//  1 reset: resetn=0 mid-REQ -> mem_req=0, sb_empty=1, st_ready=1 same cycle.
//  2 sb addr=0x1003 data=0xAB000000 -> mem_addr=0x1000 wstrb=1000 wdata=0xAB000000, pop on data_ok.
//  3 sh addr=0x2001 -> st_err=1, count stays 0; sw addr=0x2002 -> st_err=1.
//  4 push DEPTH stores, hold mem_addr_ok=0 -> st_ready=0 after 4th; grant -> in-order drain.
//  5 addr_ok&data_ok same cycle on back-to-back entries -> one write per 1 REQ cycle, no WAIT.
//  6 RAW_CHK_EN: queued sw 0x3000, ld 0x3002 -> ld_conflict=1; ld 0x3004 -> 0; macro off -> 1.

Source files
------------

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_write_buffer
// Purpose  : Posted-store FIFO between the MEM-stage store-lane aligner and
//            the data-side memory port. Lane-aligned stores are checked for
//            alignment, given byte strobes and queued. They are then drained
//            in order with at most one write outstanding over a
//            req / addr_ok / data_ok handshake. This lets the pipeline retire
//            a store without waiting for the memory write to complete.
// Params   : DEPTH - FIFO entries (power of two, 2..16)
//            AW    - address width
// Ports    : clk, resetn                     clock, async active-low reset
//            st_valid/st_size/st_addr/st_wdata
//                                            store request from MEM stage
//            st_ready, st_err                accept / illegal-request flags
//            sb_empty                        nothing queued, nothing in flight
//            ld_valid/ld_addr, ld_conflict   load probe and stall request
//            mem_req/mem_addr/mem_size/mem_wstrb/mem_wdata
//                                            registered write request
//            mem_addr_ok, mem_data_ok        memory accept / completion
// Config   : STBUF_RAW_CHK_EN - when defined, ld_conflict does an exact
//            word-address match against queued entries and the incoming
//            store. Otherwise any pending store stalls a load.
// Revision : 1.0 - initial release
// ============================================================================
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          st_valid,
    input  logic [1:0]    st_size,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_wdata,
    output logic          st_ready,
    output logic          st_err,
    output logic          sb_empty,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_conflict,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    mem_size,
    output logic [3:0]    mem_wstrb,
    output logic [31:0]   mem_wdata,
    input  logic          mem_addr_ok,
    input  logic          mem_data_ok
);

    localparam int               C_PW        = $clog2(DEPTH);
    localparam int               C_CW        = C_PW + 1;
    localparam logic [C_CW-1:0]  C_DEPTH_CNT = C_CW'(DEPTH);
    localparam logic [C_CW-1:0]  C_ONE_CNT   = C_CW'(1);
    localparam logic [C_PW-1:0]  C_ONE_PTR   = C_PW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Entry storage. Only the word address is kept, because the strobes
    // already carry the byte offset.
    logic [AW-3:0] r_addr_q [DEPTH];
    logic [1:0]    r_size_q [DEPTH];
    logic [3:0]    r_strb_q [DEPTH];
    logic [31:0]   r_data_q [DEPTH];

    logic [C_PW-1:0] r_wr_ptr;
    logic [C_PW-1:0] r_rd_ptr;
    logic [C_CW-1:0] r_count;
    state_t          r_state;

    logic            r_mem_req;
    logic [AW-1:0]   r_mem_addr;
    logic [1:0]      r_mem_size;
    logic [3:0]      r_mem_wstrb;
    logic [31:0]     r_mem_wdata;

    logic [3:0]      w_strb;
    logic            w_illegal;
    logic            w_push;
    logic            w_pop;
    logic [C_PW-1:0] w_rd_next;
    logic            w_more;
    logic            w_unused;

    // ------------------------------------------------------------------
    // Strobe generation and legality
    // ------------------------------------------------------------------
    always_comb begin
        w_strb    = 4'b0000;
        w_illegal = 1'b0;
        case (st_size)
            2'b00: w_strb = 4'b0001 << st_addr[1:0];
            2'b01: begin
                w_illegal = st_addr[0];
                w_strb    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_illegal = (st_addr[1:0] != 2'b00);
                w_strb    = 4'b1111;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign st_err   = st_valid & w_illegal;
    // A pop in the same cycle does not free a slot for a push into a full FIFO.
    assign st_ready = (r_count != C_DEPTH_CNT);
    assign sb_empty = (r_count == '0) && (r_state == S_IDLE);

    assign w_push    = st_valid & st_ready & ~w_illegal;
    assign w_pop     = ((r_state == S_REQ)  & mem_addr_ok & mem_data_ok) |
                       ((r_state == S_WAIT) & mem_data_ok);
    assign w_rd_next = r_rd_ptr + C_ONE_PTR;
    // An entry pushed in the popping cycle is not yet readable. That case
    // returns through IDLE, which gives the normal two-cycle latency.
    assign w_more    = (r_count > C_ONE_CNT);

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed; occupancy is tracked by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_wr_ptr] <= st_addr[AW-1:2];
            r_size_q[r_wr_ptr] <= st_size;
            r_strb_q[r_wr_ptr] <= w_strb;
            r_data_q[r_wr_ptr] <= st_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + C_ONE_PTR;
            if (w_pop)  r_rd_ptr <= w_rd_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE_CNT;
                2'b01:   r_count <= r_count - C_ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM with registered memory-side outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_size  <= '0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state     <= S_REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= {r_addr_q[r_rd_ptr], 2'b00};
                        r_mem_size  <= r_size_q[r_rd_ptr];
                        r_mem_wstrb <= r_strb_q[r_rd_ptr];
                        r_mem_wdata <= r_data_q[r_rd_ptr];
                    end
                end
                S_REQ: begin
                    if (mem_addr_ok && mem_data_ok) begin
                        if (w_more) begin
                            r_mem_addr  <= {r_addr_q[w_rd_next], 2'b00};
                            r_mem_size  <= r_size_q[w_rd_next];
                            r_mem_wstrb <= r_strb_q[w_rd_next];
                            r_mem_wdata <= r_data_q[w_rd_next];
                        end else begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end else if (mem_addr_ok) begin
                        r_state   <= S_WAIT;
                        r_mem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_data_ok) begin
                        if (w_more) begin
                            r_state     <= S_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_addr  <= {r_addr_q[w_rd_next], 2'b00};
                            r_mem_size  <= r_size_q[w_rd_next];
                            r_mem_wstrb <= r_strb_q[w_rd_next];
                            r_mem_wdata <= r_data_q[w_rd_next];
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_size  = r_mem_size;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;

    // ------------------------------------------------------------------
    // Load-after-store hazard detection
    // ------------------------------------------------------------------
`ifdef STBUF_RAW_CHK_EN
    logic [DEPTH-1:0] w_hit;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_raw
        logic [C_PW-1:0] w_off;
        // A slot is live when its distance from the head is below the count.
        // The in-flight head is still counted, so it is included.
        assign w_off     = C_PW'(gi) - r_rd_ptr;
        assign w_hit[gi] = ({1'b0, w_off} < r_count) &&
                           (r_addr_q[gi] == ld_addr[AW-1:2]);
    end

    assign ld_conflict = ld_valid &
                         ((|w_hit) |
                          (st_valid & ~w_illegal &
                           (st_addr[AW-1:2] == ld_addr[AW-1:2])));
`else
    assign ld_conflict = ld_valid & (~sb_empty | (st_valid & ~w_illegal));
`endif

    assign w_unused = ^ld_addr;

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_write_buffer
// Purpose  : Self-checking bench for store_write_buffer. Directed stores push
//            their expected memory write into a scoreboard queue. A monitor
//            pops and compares each write that the memory accepts. A
//            responder process models split, combined and stalled memory
//            handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

`ifdef STBUF_RAW_CHK_EN
    localparam bit C_RAW = 1'b1;
`else
    localparam bit C_RAW = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          st_valid;
    logic [1:0]    st_size;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_wdata;
    logic          st_ready;
    logic          st_err;
    logic          sb_empty;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_conflict;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_size;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_wdata;
    logic          mem_addr_ok;
    logic          mem_data_ok;

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .st_valid    (st_valid),
        .st_size     (st_size),
        .st_addr     (st_addr),
        .st_wdata    (st_wdata),
        .st_ready    (st_ready),
        .st_err      (st_err),
        .sb_empty    (sb_empty),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_size    (mem_size),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  mode     = 0;   // 0 split, 1 combined, 2 stall
    bit  pending  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Memory responder: decides the handshake once per cycle, after the edge.
    initial begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) begin
                mem_addr_ok = 1'b0; mem_data_ok = 1'b0; pending = 1'b0;
            end else if (pending) begin
                mem_addr_ok = 1'b0; mem_data_ok = 1'b1; pending = 1'b0;
            end else if (mem_req && mode == 1) begin
                mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
            end else if (mem_req && mode == 0) begin
                mem_addr_ok = 1'b1; mem_data_ok = 1'b0; pending = 1'b1;
            end else begin
                mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
            end
        end
    end

    // Monitor: every accepted request is compared with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && mem_req && mem_addr_ok) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: actual addr %h required none", mem_addr);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("mem_addr",  mem_addr,  e.addr);
                    check("mem_size",  {30'd0, mem_size},  {30'd0, e.size});
                    check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.strb});
                    check("mem_wdata", mem_wdata, e.data);
                end
            end
        end
    end

    // Drive one store. Legal stores wait for st_ready and queue their write.
    task automatic push(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                        input bit illegal, input logic [31:0] maddr, input logic [3:0] strb);
        int n;
        wr_t e;
        @(negedge clk);
        st_valid = 1'b1; st_size = sz; st_addr = a; st_wdata = d;
        #1;
        check("st_err", {31'd0, st_err}, {31'd0, illegal});
        if (!illegal) begin
            n = 0;
            while (!st_ready && n < 200) begin
                @(negedge clk); #1; n++;
            end
            if (!st_ready) begin
                n_checks++; n_fail++;
                $display("FAIL st_ready_timeout: actual 0 required 1");
            end else begin
                e.addr = maddr; e.size = sz; e.strb = strb; e.data = d;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        st_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        @(negedge clk);
        while (!sb_empty && n < 300) begin
            @(negedge clk); n++;
        end
        check("drain_sb_empty", {31'd0, sb_empty}, 32'd1);
        check("scoreboard_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        resetn = 1'b0; st_valid = 1'b0; st_size = 2'b00; st_addr = '0; st_wdata = '0;
        ld_valid = 1'b0; ld_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        // Test 1a: reset state
        check("rst_mem_req",  {31'd0, mem_req},  32'd0);
        check("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
        check("rst_st_ready", {31'd0, st_ready}, 32'd1);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Test 1b: reset in the middle of a stalled request
        mode = 2;
        push(2'b10, 32'h0000_8000, 32'h5555_AAAA, 1'b0, 32'h0000_8000, 4'b1111);
        repeat (3) @(negedge clk);
        check("stall_mem_req", {31'd0, mem_req}, 32'd1);
        resetn = 1'b0;
        #1;
        check("midrst_mem_req",  {31'd0, mem_req},  32'd0);
        check("midrst_sb_empty", {31'd0, sb_empty}, 32'd1);
        check("midrst_st_ready", {31'd0, st_ready}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("no_replay_mem_req",  {31'd0, mem_req},  32'd0);
        check("no_replay_sb_empty", {31'd0, sb_empty}, 32'd1);

        // Test 2: byte store on lane 3, minimum latency, split handshake
        mode = 0;
        push(2'b00, 32'h0000_1003, 32'hAB00_0000, 1'b0, 32'h0000_1000, 4'b1000);
        check("lat_req_after_enq", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_req_2nd_edge", {31'd0, mem_req}, 32'd1);
        wait_empty();

        // Test 3: illegal requests are rejected and not queued
        push(2'b01, 32'h0000_2001, 32'h1111_1111, 1'b1, 32'h0, 4'b0);
        push(2'b10, 32'h0000_2002, 32'h2222_2222, 1'b1, 32'h0, 4'b0);
        push(2'b11, 32'h0000_2000, 32'h3333_3333, 1'b1, 32'h0, 4'b0);
        @(negedge clk);
        st_size = 2'b11; st_addr = 32'h0000_2001;
        #1;
        check("st_err_no_valid", {31'd0, st_err}, 32'd0);
        repeat (3) @(negedge clk);
        check("illegal_sb_empty", {31'd0, sb_empty}, 32'd1);
        check("illegal_mem_req",  {31'd0, mem_req},  32'd0);

        // Test 4: fill the buffer against a stalled memory, then drain in order
        mode = 2;
        push(2'b01, 32'h0000_4002, 32'h1234_0000, 1'b0, 32'h0000_4000, 4'b1100);
        push(2'b00, 32'h0000_4001, 32'h0000_CD00, 1'b0, 32'h0000_4000, 4'b0010);
        push(2'b10, 32'h0000_4008, 32'hCAFE_F00D, 1'b0, 32'h0000_4008, 4'b1111);
        push(2'b01, 32'h0000_400C, 32'h0000_5678, 1'b0, 32'h0000_400C, 4'b0011);
        @(negedge clk);
        check("full_st_ready", {31'd0, st_ready}, 32'd0);
        check("full_mem_req",  {31'd0, mem_req},  32'd1);
        check("full_head_addr", mem_addr, 32'h0000_4000);
        check("full_head_strb", {28'd0, mem_wstrb}, 32'd12);
        mode = 0;
        wait_empty();

        // Test 5: combined addr_ok/data_ok gives one write per REQ cycle
        mode = 2;
        push(2'b00, 32'h0000_7000, 32'h0000_0011, 1'b0, 32'h0000_7000, 4'b0001);
        push(2'b00, 32'h0000_7002, 32'h0022_0000, 1'b0, 32'h0000_7000, 4'b0100);
        push(2'b10, 32'h0000_7004, 32'h3333_3333, 1'b0, 32'h0000_7004, 4'b1111);
        @(negedge clk);
        mode = 1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) k++;
            if (sb_empty) break;
        end
        check("b2b_req_cycles", k, 32'd3);
        check("b2b_sb_empty", {31'd0, sb_empty}, 32'd1);
        check("b2b_scoreboard_left", exp_q.size(), 32'd0);

        // Test 6: load conflict probe
        mode = 2;
        push(2'b10, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 32'h0000_3000, 4'b1111);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 32'h0000_3002;
        #1;
        check("raw_same_word", {31'd0, ld_conflict}, 32'd1);
        ld_addr = 32'h0000_3004;
        #1;
        check("raw_other_word", {31'd0, ld_conflict}, C_RAW ? 32'd0 : 32'd1);
        ld_valid = 1'b0;
        #1;
        check("raw_no_ld_valid", {31'd0, ld_conflict}, 32'd0);
        mode = 1;
        wait_empty();
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 32'h0000_5000;
        #1;
        check("raw_empty", {31'd0, ld_conflict}, 32'd0);
        st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h0000_5000; st_wdata = 32'h0;
        #1;
        check("raw_incoming_match", {31'd0, ld_conflict}, 32'd1);
        ld_addr = 32'h0000_6000;
        #1;
        check("raw_incoming_other", {31'd0, ld_conflict}, C_RAW ? 32'd0 : 32'd1);
        st_valid = 1'b0; ld_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("final_sb_empty", {31'd0, sb_empty}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
